// File: rtl/leaf_port_fifo_bank.sv
// Bank of NUM_CH independent first-word-fall-through FIFOs between the leaf
// interface and the user kernel. It provides per-channel occupancy, almost-full, output hold and a global flush.
module leaf_port_fifo_bank #(
    parameter int NUM_CH       = 6,
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4,
    parameter int AF_LEVEL     = 12
) (
    input  logic                              clk_user,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic [NUM_CH*PAYLOAD_BITS-1:0]    din,
    input  logic [NUM_CH-1:0]                 vld_in,
    output logic [NUM_CH-1:0]                 ack_out,
    output logic [NUM_CH*PAYLOAD_BITS-1:0]    dout,
    output logic [NUM_CH-1:0]                 vld_out,
    input  logic [NUM_CH-1:0]                 ack_in,
    input  logic [NUM_CH-1:0]                 hold,
    output logic [NUM_CH*(DEPTH_BITS+1)-1:0]  count,
    output logic [NUM_CH-1:0]                 almost_full
);

    localparam int              DEPTH      = 1 << DEPTH_BITS;
    localparam int              CW         = DEPTH_BITS + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_COUNT   = CW'(AF_LEVEL);

    // Write side stays closed until the first clock edge after reset is released.
    logic rdy_en_reg;

    always_ff @(posedge clk_user) begin
        if (!reset_n) begin
            rdy_en_reg <= 1'b0;
        end else begin
            rdy_en_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [PAYLOAD_BITS-1:0] mem [DEPTH];
            logic [DEPTH_BITS-1:0]   wr_ptr_reg;
            logic [DEPTH_BITS-1:0]   wr_ptr_next;
            logic [DEPTH_BITS-1:0]   rd_ptr_reg;
            logic [DEPTH_BITS-1:0]   rd_ptr_next;
            logic [CW-1:0]           count_reg;
            logic [CW-1:0]           count_next;
            logic                    wr_fire;
            logic                    rd_fire;

            // Write readiness depends only on registered state, so there is
            // no combinational path from vld_in or ack_in to the handshakes.
            assign ack_out[gi]     = rdy_en_reg & (count_reg != FULL_COUNT);
            assign vld_out[gi]     = (count_reg != '0) & ~hold[gi];
            assign wr_fire         = vld_in[gi] & ack_out[gi];
            assign rd_fire         = vld_out[gi] & ack_in[gi];
            assign almost_full[gi] = (count_reg >= AF_COUNT);

            assign dout[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = mem[rd_ptr_reg];
            assign count[gi*CW +: CW]                    = count_reg;

            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                count_next  = count_reg;
                if (flush) begin
                    wr_ptr_next = '0;
                    rd_ptr_next = '0;
                    count_next  = '0;
                end else begin
                    if (wr_fire) begin
                        wr_ptr_next = wr_ptr_reg + DEPTH_BITS'(1);
                    end
                    if (rd_fire) begin
                        rd_ptr_next = rd_ptr_reg + DEPTH_BITS'(1);
                    end
                    case ({wr_fire, rd_fire})
                        2'b10:   count_next = count_reg + CW'(1);
                        2'b01:   count_next = count_reg - CW'(1);
                        default: count_next = count_reg;
                    endcase
                end
            end

            always_ff @(posedge clk_user) begin
                if (!reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    count_reg  <= count_next;
                end
            end

            // Storage is never cleared; a write during flush is simply dropped.
            always_ff @(posedge clk_user) begin
                if (reset_n && !flush && wr_fire) begin
                    mem[wr_ptr_reg] <= din[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_leaf_port_fifo_bank.sv
// Scenario bench for leaf_port_fifo_bank: per-channel queue scoreboard checks
// handshakes, occupancy and head data every cycle, plus scenario-specific checks.
module tb_leaf_port_fifo_bank;

    localparam int NCH = 6;
    localparam int PB  = 32;
    localparam int CW  = 5;

    logic               clk_user = 1'b0;
    logic               reset_n;
    logic               flush;
    logic [NCH*PB-1:0]  din;
    logic [NCH-1:0]     vld_in;
    logic [NCH-1:0]     ack_out;
    logic [NCH*PB-1:0]  dout;
    logic [NCH-1:0]     vld_out;
    logic [NCH-1:0]     ack_in;
    logic [NCH-1:0]     hold;
    logic [NCH*CW-1:0]  count;
    logic [NCH-1:0]     almost_full;

    int ncmp = 0;
    int nerr = 0;

    logic [PB-1:0] q [NCH][$];
    bit            rdy_m = 1'b0;

    leaf_port_fifo_bank #(
        .NUM_CH(NCH), .PAYLOAD_BITS(PB), .DEPTH_BITS(4), .AF_LEVEL(12)
    ) dut (
        .clk_user(clk_user), .reset_n(reset_n), .flush(flush), .din(din),
        .vld_in(vld_in), .ack_out(ack_out), .dout(dout), .vld_out(vld_out),
        .ack_in(ack_in), .hold(hold), .count(count), .almost_full(almost_full)
    );

    always #5 clk_user = ~clk_user;

    // One clock: compare outputs with the model at negedge, then advance the model.
    task automatic step();
        logic [NCH-1:0]    e_ack;
        logic [NCH-1:0]    e_vld;
        logic [NCH-1:0]    e_af;
        logic [NCH*CW-1:0] e_cnt;
        @(negedge clk_user);
        for (int c = 0; c < NCH; c++) begin
            e_ack[c]          = rdy_m && (q[c].size() < 16);
            e_vld[c]          = (q[c].size() != 0) && !hold[c];
            e_af[c]           = (q[c].size() >= 12);
            e_cnt[c*CW +: CW] = CW'(q[c].size());
        end
        ncmp += 4;
        if (ack_out !== e_ack) begin
            nerr++; $display("FAIL ack_out: got %b want %b at %0t", ack_out, e_ack, $time);
        end
        if (vld_out !== e_vld) begin
            nerr++; $display("FAIL vld_out: got %b want %b at %0t", vld_out, e_vld, $time);
        end
        if (almost_full !== e_af) begin
            nerr++; $display("FAIL almost_full: got %b want %b at %0t", almost_full, e_af, $time);
        end
        if (count !== e_cnt) begin
            nerr++; $display("FAIL count: got %h want %h at %0t", count, e_cnt, $time);
        end
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) q[c].delete();
            rdy_m = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (flush) begin
                    q[c].delete();
                end else begin
                    if (e_vld[c] && ack_in[c]) begin
                        ncmp++;
                        if (dout[c*PB +: PB] !== q[c][0]) begin
                            nerr++;
                            $display("FAIL dout ch%0d: got %h want %h at %0t", c, dout[c*PB +: PB], q[c][0], $time);
                        end
                        void'(q[c].pop_front());
                    end
                    if (vld_in[c] && e_ack[c]) q[c].push_back(din[c*PB +: PB]);
                end
            end
            rdy_m = 1'b1;
        end
        @(posedge clk_user);
        #1;
    endtask

    task automatic idle_inputs();
        vld_in = '0; ack_in = '0; hold = '0; flush = 1'b0; din = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ncmp += 3;
        if (ack_out !== 6'b0)  begin nerr++; $display("FAIL reset_ack: got %b want 000000", ack_out); end
        if (vld_out !== 6'b0)  begin nerr++; $display("FAIL reset_vld: got %b want 000000", vld_out); end
        if (count !== '0)      begin nerr++; $display("FAIL reset_count: got %h want 0", count); end
        reset_n = 1'b1;
        step();
        ncmp++;
        if (ack_out !== 6'b111111) begin
            nerr++; $display("FAIL release_ack: got %b want 111111", ack_out);
        end
        $display("test_reset: done");
    endtask

    task automatic test_order();
        idle_inputs();
        ncmp++;
        if (vld_out[0] !== 1'b0) begin nerr++; $display("FAIL order_vld_pre: got %b want 0", vld_out[0]); end
        for (int i = 1; i <= 5; i++) begin
            vld_in[0] = 1'b1; din[31:0] = 32'(i);
            step();
            if (i == 1) begin
                ncmp++;
                if (vld_out[0] !== 1'b1) begin nerr++; $display("FAIL order_latency: got %b want 1", vld_out[0]); end
            end
        end
        vld_in[0] = 1'b0;
        ncmp++;
        if (count[4:0] !== 5'd5) begin nerr++; $display("FAIL order_count5: got %0d want 5", count[4:0]); end
        ack_in[0] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ncmp++;
        if (count[4:0] !== 5'd0) begin nerr++; $display("FAIL order_count0: got %0d want 0", count[4:0]); end
        idle_inputs();
        $display("test_order: done");
    endtask

    task automatic test_full_wrap();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            vld_in[2] = 1'b1; din[2*PB +: PB] = 32'h200 + 32'(i);
            step();
            ncmp++;
            if (almost_full[2] !== (i + 1 >= 12)) begin
                nerr++; $display("FAIL af_fill%0d: got %b want %b", i + 1, almost_full[2], (i + 1 >= 12));
            end
        end
        ncmp += 2;
        if (ack_out[2] !== 1'b0)     begin nerr++; $display("FAIL full_ack: got %b want 0", ack_out[2]); end
        if (count[14:10] !== 5'd16)  begin nerr++; $display("FAIL full_count: got %0d want 16", count[14:10]); end
        din[2*PB +: PB] = 32'hDEAD;
        step();
        ncmp++;
        if (count[14:10] !== 5'd16)  begin nerr++; $display("FAIL full_reject: got %0d want 16", count[14:10]); end
        vld_in[2] = 1'b0; ack_in[2] = 1'b1;
        step();
        vld_in[2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din[2*PB +: PB] = 32'h300 + 32'(i);
            step();
        end
        ncmp++;
        if (count[14:10] !== 5'd15) begin nerr++; $display("FAIL wrap_count: got %0d want 15", count[14:10]); end
        vld_in[2] = 1'b0;
        for (int i = 0; i < 16; i++) step();
        idle_inputs();
        $display("test_full_wrap: done");
    endtask

    task automatic test_hold();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            vld_in[5] = 1'b1; din[5*PB +: PB] = 32'h500 + 32'(i);
            step();
        end
        vld_in[5] = 1'b0; hold[5] = 1'b1; ack_in[5] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        ncmp += 2;
        if (vld_out[5] !== 1'b0)    begin nerr++; $display("FAIL hold_vld: got %b want 0", vld_out[5]); end
        if (count[29:25] !== 5'd3)  begin nerr++; $display("FAIL hold_count: got %0d want 3", count[29:25]); end
        hold[5] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ncmp++;
        if (count[29:25] !== 5'd0)  begin nerr++; $display("FAIL hold_drain: got %0d want 0", count[29:25]); end
        idle_inputs();
        $display("test_hold: done");
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            vld_in[1] = 1'b1; din[PB +: PB] = 32'h100 + 32'(i);
            step();
        end
        flush = 1'b1; din[PB +: PB] = 32'hBAD; ack_in[1] = 1'b1;
        step();
        flush = 1'b0; vld_in[1] = 1'b0; ack_in[1] = 1'b0;
        ncmp += 2;
        if (count[9:5] !== 5'd0)  begin nerr++; $display("FAIL flush_count: got %0d want 0", count[9:5]); end
        if (vld_out[1] !== 1'b0)  begin nerr++; $display("FAIL flush_vld: got %b want 0", vld_out[1]); end
        vld_in[1] = 1'b1; din[PB +: PB] = 32'h1234;
        step();
        vld_in[1] = 1'b0;
        ncmp++;
        if (dout[PB +: PB] !== 32'h1234) begin
            nerr++; $display("FAIL flush_head: got %h want 00001234", dout[PB +: PB]);
        end
        ack_in[1] = 1'b1;
        step();
        idle_inputs();
        $display("test_flush: done");
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 10000; n++) begin
            vld_in = NCH'($urandom);
            ack_in = NCH'($urandom);
            hold   = NCH'($urandom & $urandom & $urandom);
            for (int c = 0; c < NCH; c++) din[c*PB +: PB] = $urandom;
            step();
        end
        idle_inputs();
        ack_in = '1;
        for (int i = 0; i < 20; i++) step();
        ncmp++;
        if (count !== '0) begin nerr++; $display("FAIL random_drain: got %h want 0", count); end
        idle_inputs();
        $display("test_random: done");
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        @(posedge clk_user);
        #1;
        test_reset();
        test_order();
        test_full_wrap();
        test_hold();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/leaf_port_fifo_bank.md
Name: leaf_port_fifo_bank

Overview:
- Parametrised bank of NUM_CH independent first-word-fall-through FIFOs, one per channel.
- Sits between leaf_interface and the user kernel on the clk_user side of a leaf shell.
- Decouples the interface vld/ack ports from the user kernel and generalises the fixed 6-in/2-out wiring to any channel count and depth.
- Adds per-channel buffering, occupancy reporting, almost-full flags, per-channel output hold, and a global flush.

Parameters:
NUM_CH, 6, number of independent channels
PAYLOAD_BITS, 32, data width per channel
DEPTH_BITS, 4, log2 of FIFO depth per channel (depth 16); depth must be a power of 2
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2^DEPTH_BITS

Ports:
clk_user  in  1  user clock; all logic on its rising edge
reset_n  in  1  synchronous, active-low reset
flush  in  1  synchronous clear of all channels
din  in  NUM_CH*PAYLOAD_BITS  write data; channel i at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
vld_in  in  NUM_CH  producer valid, per channel
ack_out  out  NUM_CH  ready to producer, per channel
dout  out  NUM_CH*PAYLOAD_BITS  head-of-FIFO data, same packing as din
vld_out  out  NUM_CH  consumer valid, per channel
ack_in  in  NUM_CH  consumer accept, per channel
hold  in  NUM_CH  per-channel output pause
count  out  NUM_CH*(DEPTH_BITS+1)  occupancy per channel, packed as din
almost_full  out  NUM_CH  count >= AF_LEVEL, per channel

Behaviour:
- Transfer rule, both sides: a beat moves only when vld and ack are both high in the same cycle. vld_in while ack_out=0 is ignored; no overflow is possible.
- Channels are fully independent; the only shared controls are reset_n and flush.
- rdy_en register:
  - Cleared by reset.
  - Set to 1 at the first edge where reset_n=1.
  - ack_out[i] = rdy_en & (count[i] != 2^DEPTH_BITS).
  - ack_out does not depend on ack_in, so a full FIFO does not accept a write even when a read happens in the same cycle.
- vld_out[i] = (count[i] != 0) & ~hold[i].
- dout[i] = mem[i][rd_ptr[i]] (asynchronous read, LUTRAM). dout is don't-care when count=0.
- hold[i]=1 forces vld_out[i]=0 and ignores ack_in[i]. The write side is unaffected.
- Latency: a beat written at edge k shows vld_out at k+1 (cycle following edge k) if the FIFO was empty; throughput 1 beat/cycle/channel.
- Pointers: wr_ptr and rd_ptr are DEPTH_BITS wide and wrap naturally at depth. count is DEPTH_BITS+1 wide.
- Count update per cycle: +1 on write only, -1 on read only, unchanged on simultaneous write and read (legal only when 0 < count < depth).
- Simultaneous write and read on an empty FIFO: impossible, since vld_out=0; the write proceeds and count becomes 1.
- almost_full is combinational from count.
- Reset (reset_n=0 at an edge):
  - Pointers, counts and rdy_en go to 0.
  - Resulting outputs: ack_out=0, vld_out=0, count=0, almost_full=0.
  - Memory contents are not cleared.
  - Reset mid-stream discards all buffered data.
- Flush (flush=1, reset_n=1):
  - Pointers and counts go to 0 at the edge.
  - Any write or read in that cycle is dropped; the producer sees ack_out high but the beat is discarded.
  - rdy_en is unaffected.
  - Priority: reset > flush > normal.
- No combinational path from vld_in to ack_out, or from ack_in to vld_out.

Test Plan:
- Reset release: hold reset_n=0 for 3 cycles, then 1 -> ack_out=0, vld_out=0, count=0 while in reset; ack_out=6'b111111 from the cycle after the first edge with reset_n=1.
- Ordering and latency: write 0x00000001..0x00000005 back-to-back on ch0 with ack_in[0]=0 -> count[0]=5, vld_out[0] rises 1 cycle after the first write; then ack_in[0]=1 drains 1..5 in order, one per cycle; count returns to 0.
- Full and wrap: ch2 write 16 beats -> ack_out[2]=0 at count=16, almost_full[2]=1 from count=12; a further vld_in beat (0xDEAD) is not accepted; then 40 cycles of simultaneous read/write -> pointers wrap, data in order, count stays constant.
- Hold: ch5 loaded with 3 beats, hold[5]=1, ack_in[5]=1 -> vld_out[5]=0, count stays 3; release hold -> 3 beats drain on consecutive cycles.
- Flush mid-stream: ch1 count=7, assert flush for 1 cycle concurrently with a write and a read -> count[1]=0 next cycle, vld_out[1]=0, neither beat observed; a write afterwards appears as the new head.
- Independence: random vld_in/ack_in/hold on all 6 channels for 10k cycles -> scoreboard per channel matches, no cross-channel corruption, count matches the model every cycle.
